// File: rtl/dht11_pkg.sv
// Shared types and constants for the DHT11 read controller.
// StRetryWait exists only when DHT11_AUTO_RETRY_EN is defined.
package dht11_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StStartLow,
        StWaitResp,
        StRespLow,
        StRespHigh,
        StBitLow,
        StBitHigh,
        StCheck,
        StError
`ifdef DHT11_AUTO_RETRY_EN
        , StRetryWait
`endif
    } dht_state_e;

    localparam logic [1:0] ERR_NONE   = 2'd0;
    localparam logic [1:0] ERR_NORESP = 2'd1;
    localparam logic [1:0] ERR_BIT    = 2'd2;
    localparam logic [1:0] ERR_CSUM   = 2'd3;

    localparam int unsigned DHT_BITS = 40;

    // Sum of the four data bytes, mod 256, must equal the trailing checksum byte.
    function automatic logic csum_ok(input logic [DHT_BITS-1:0] frame);
        logic [7:0] sum;
        sum = frame[39:32] + frame[31:24] + frame[23:16] + frame[15:8];
        return sum == frame[7:0];
    endfunction

endpackage

// File: rtl/dht11_in_sync.sv
// Two-flop synchronizer for the DHT11 pad input; resets to 1 (idle line is pulled high).
module dht11_in_sync (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_d,
    output logic o_q
);

    logic [1:0] r_sync;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], i_d};
        end
    end

    assign o_q = r_sync[1];

endmodule

// File: rtl/dht11_read_ctrl.sv
// DHT11 single-wire read sequencer, timed in 1 us ticks.
// Define DHT11_AUTO_RETRY_EN to retry once on a no-response or bit-timeout error.
module dht11_read_ctrl
    import dht11_pkg::*;
#(
    parameter int unsigned START_LOW_US    = 18000,
    parameter int unsigned RESP_TIMEOUT_US = 100,
    parameter int unsigned BIT_THRESH_US   = 50,
    parameter int unsigned CNT_W           = 15
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_tick_1us,
    input  logic       i_start,
    input  logic       i_dht_in,
    output logic       o_dht_oe,
    output logic       o_busy,
    output logic [7:0] o_hum_int,
    output logic [7:0] o_hum_dec,
    output logic [7:0] o_tmp_int,
    output logic [7:0] o_tmp_dec,
    output logic       o_valid,
    output logic       o_err,
    output logic [1:0] o_err_code
);

    dht_state_e          r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [5:0]          r_bit_idx;
    logic [DHT_BITS-1:0] r_shift;
    logic                r_dht_oe;
    logic                r_busy;
    logic                r_valid;
    logic                r_err;
    logic [1:0]          r_err_code;
    logic [7:0]          r_hum_int;
    logic [7:0]          r_hum_dec;
    logic [7:0]          r_tmp_int;
    logic [7:0]          r_tmp_dec;
`ifdef DHT11_AUTO_RETRY_EN
    logic                r_retried;
`endif

    logic             w_dht;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_start_done;
    logic             w_timeout;
    logic             w_bit;

    dht11_in_sync u_in_sync (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_d     (i_dht_in),
        .o_q     (w_dht)
    );

    // Limits fire on the tick that brings the count to the limit, so a wait lasts exactly N ticks.
    assign w_cnt_inc    = r_cnt + CNT_W'(i_tick_1us);
    assign w_start_done = (w_cnt_inc == CNT_W'(START_LOW_US));
    assign w_timeout    = (w_cnt_inc == CNT_W'(RESP_TIMEOUT_US));
    assign w_bit        = (r_cnt > CNT_W'(BIT_THRESH_US));

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state    <= StIdle;
            r_cnt      <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_dht_oe   <= 1'b0;
            r_busy     <= 1'b0;
            r_valid    <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= ERR_NONE;
            r_hum_int  <= '0;
            r_hum_dec  <= '0;
            r_tmp_int  <= '0;
            r_tmp_dec  <= '0;
`ifdef DHT11_AUTO_RETRY_EN
            r_retried  <= 1'b0;
`endif
        end else begin
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            r_cnt   <= w_cnt_inc;
            case (r_state)
                StIdle: begin
                    r_cnt <= '0;
                    if (i_start) begin
                        r_state    <= StStartLow;
                        r_dht_oe   <= 1'b1;
                        r_busy     <= 1'b1;
                        r_bit_idx  <= '0;
                        r_shift    <= '0;
                        r_err_code <= ERR_NONE;
`ifdef DHT11_AUTO_RETRY_EN
                        r_retried  <= 1'b0;
`endif
                    end
                end
                StStartLow: begin
                    if (w_start_done) begin
                        r_state  <= StWaitResp;
                        r_dht_oe <= 1'b0;
                        r_cnt    <= '0;
                    end
                end
                StWaitResp: begin
                    if (!w_dht) begin
                        r_state <= StRespLow;
                        r_cnt   <= '0;
                    end else if (w_timeout) begin
                        r_state    <= StError;
                        r_err_code <= ERR_NORESP;
                        r_cnt      <= '0;
                    end
                end
                StRespLow: begin
                    if (w_dht) begin
                        r_state <= StRespHigh;
                        r_cnt   <= '0;
                    end else if (w_timeout) begin
                        r_state    <= StError;
                        r_err_code <= ERR_NORESP;
                        r_cnt      <= '0;
                    end
                end
                StRespHigh: begin
                    if (!w_dht) begin
                        r_state <= StBitLow;
                        r_cnt   <= '0;
                    end else if (w_timeout) begin
                        r_state    <= StError;
                        r_err_code <= ERR_NORESP;
                        r_cnt      <= '0;
                    end
                end
                StBitLow: begin
                    if (w_dht) begin
                        r_state <= StBitHigh;
                        r_cnt   <= '0;
                    end else if (w_timeout) begin
                        r_state    <= StError;
                        r_err_code <= ERR_BIT;
                        r_cnt      <= '0;
                    end
                end
                StBitHigh: begin
                    if (!w_dht) begin
                        r_shift   <= {r_shift[DHT_BITS-2:0], w_bit};
                        r_bit_idx <= r_bit_idx + 6'd1;
                        r_state   <= (r_bit_idx == 6'(DHT_BITS - 1)) ? StCheck : StBitLow;
                        r_cnt     <= '0;
                    end else if (w_timeout) begin
                        r_state    <= StError;
                        r_err_code <= ERR_BIT;
                        r_cnt      <= '0;
                    end
                end
                StCheck: begin
                    r_cnt <= '0;
                    if (csum_ok(r_shift)) begin
                        r_hum_int  <= r_shift[39:32];
                        r_hum_dec  <= r_shift[31:24];
                        r_tmp_int  <= r_shift[23:16];
                        r_tmp_dec  <= r_shift[15:8];
                        r_valid    <= 1'b1;
                        r_err_code <= ERR_NONE;
                        r_busy     <= 1'b0;
                        r_state    <= StIdle;
                    end else begin
                        r_err_code <= ERR_CSUM;
                        r_state    <= StError;
                    end
                end
                StError: begin
                    r_dht_oe <= 1'b0;
                    r_cnt    <= '0;
`ifdef DHT11_AUTO_RETRY_EN
                    if (!r_retried && r_err_code != ERR_CSUM) begin
                        r_retried <= 1'b1;
                        r_state   <= StRetryWait;
                    end else
`endif
                    begin
                        r_err   <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= StIdle;
                    end
                end
`ifdef DHT11_AUTO_RETRY_EN
                StRetryWait: begin
                    if (w_start_done) begin
                        r_state   <= StStartLow;
                        r_dht_oe  <= 1'b1;
                        r_bit_idx <= '0;
                        r_shift   <= '0;
                        r_cnt     <= '0;
                    end
                end
`endif
                default: begin
                    r_state  <= StIdle;
                    r_dht_oe <= 1'b0;
                    r_busy   <= 1'b0;
                    r_cnt    <= '0;
                end
            endcase
        end
    end

    assign o_dht_oe   = r_dht_oe;
    assign o_busy     = r_busy;
    assign o_valid    = r_valid;
    assign o_err      = r_err;
    assign o_err_code = r_err_code;
    assign o_hum_int  = r_hum_int;
    assign o_hum_dec  = r_hum_dec;
    assign o_tmp_int  = r_tmp_int;
    assign o_tmp_dec  = r_tmp_dec;

endmodule

// File: tb/tb_dht11_read_ctrl.sv
// Scoreboard bench for dht11_read_ctrl: a sensor model answers each read, expected
// valid/err events are queued per transaction and checked by an independent monitor.
module tb_dht11_read_ctrl;

    localparam int unsigned START_US = 1000;

    logic       clk;
    logic       reset;
    logic       tick;
    logic       start;
    logic       dht_in;
    logic       o_dht_oe;
    logic       o_busy;
    logic [7:0] o_hum_int;
    logic [7:0] o_hum_dec;
    logic [7:0] o_tmp_int;
    logic [7:0] o_tmp_dec;
    logic       o_valid;
    logic       o_err;
    logic [1:0] o_err_code;

    dht11_read_ctrl #(
        .START_LOW_US    (START_US),
        .RESP_TIMEOUT_US (100),
        .BIT_THRESH_US   (50),
        .CNT_W           (15)
    ) dut (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_tick_1us (tick),
        .i_start    (start),
        .i_dht_in   (dht_in),
        .o_dht_oe   (o_dht_oe),
        .o_busy     (o_busy),
        .o_hum_int  (o_hum_int),
        .o_hum_dec  (o_hum_dec),
        .o_tmp_int  (o_tmp_int),
        .o_tmp_dec  (o_tmp_dec),
        .o_valid    (o_valid),
        .o_err      (o_err),
        .o_err_code (o_err_code)
    );

    typedef struct packed {
        logic        is_err;
        logic [1:0]  code;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    int          pulse_q[$];
    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [31:0] model_data;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One tick every second clock.
    initial begin
        tick = 1'b0;
        forever begin
            @(posedge clk);
            #1 tick = ~tick;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got running, required finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Monitor: every valid/err pulse must match the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && (o_valid || o_err)) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", {62'd0, o_err, o_valid}, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("pulse_kind", {o_err, o_valid}, e.is_err ? 2'b10 : 2'b01);
                    check("pulse_err_code", o_err_code, e.code);
                    check("pulse_data", {o_hum_int, o_hum_dec, o_tmp_int, o_tmp_dec}, e.data);
                    check("pulse_busy", o_busy, 1'b0);
                    check("pulse_oe", o_dht_oe, 1'b0);
                end
            end
        end
    end

    // Measures, in ticks, how long the DUT holds the line low.
    initial begin
        int   p_cnt;
        logic p_prev;
        p_cnt  = 0;
        p_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                p_cnt  = 0;
                p_prev = 1'b0;
            end else begin
                if (o_dht_oe && tick) p_cnt++;
                if (p_prev && !o_dht_oe) begin
                    pulse_q.push_back(p_cnt);
                    p_cnt = 0;
                end
                p_prev = o_dht_oe;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic to_nontick();
        do step(); while (tick);
    endtask

    // Called at the start of a non-tick cycle; returns after n ticks at the next one.
    task automatic hold_us(input int n);
        repeat (2 * n) step();
    endtask

    task automatic send_frame(input logic [39:0] f, input int stop_bit, input bit edge_w);
        int h;
        to_nontick();
        hold_us($urandom_range(10, 40));
        dht_in = 1'b0;
        hold_us(80);
        dht_in = 1'b1;
        hold_us(80);
        for (int i = 0; i < 40; i++) begin
            if (i == stop_bit) return;
            dht_in = 1'b0;
            hold_us(50);
            dht_in = 1'b1;
            if (edge_w) h = f[39-i] ? 51 : 50;
            else        h = f[39-i] ? $urandom_range(51, 70) : $urandom_range(26, 50);
            hold_us(h);
        end
        dht_in = 1'b0;
        hold_us(50);
        dht_in = 1'b1;
    endtask

    // mode 0: full frame, 1: no sensor, 2: sensor stops at bit 20.
    task automatic transact(input int mode, input logic [39:0] f, input bit edge_w);
        exp_t e;
        int   s;
        int   k;
        s = f[39:32] + f[31:24] + f[23:16] + f[15:8];
        e.data = model_data;
        if (mode == 1) begin
            e.is_err = 1'b1;
            e.code   = 2'd1;
        end else if (mode == 2) begin
            e.is_err = 1'b1;
            e.code   = 2'd2;
        end else if (s % 256 == int'(f[7:0])) begin
            e.is_err   = 1'b0;
            e.code     = 2'd0;
            e.data     = f[39:8];
            model_data = f[39:8];
        end else begin
            e.is_err = 1'b1;
            e.code   = 2'd3;
        end
        exp_q.push_back(e);

        start = 1'b1;
        step();
        start = 1'b0;
        check("busy_after_start", o_busy, 1'b1);
        check("oe_after_start", o_dht_oe, 1'b1);
        hold_us(100);
        start = 1'b1;
        step();
        start = 1'b0;

        k = 0;
        while (o_dht_oe && k < 4 * START_US) begin
            step();
            k++;
        end
        check("oe_released", o_dht_oe, 1'b0);
        if (mode != 1) send_frame(f, (mode == 2) ? 20 : 99, edge_w);

        k = 0;
        while (o_busy && k < 4000) begin
            step();
            k++;
        end
        check("busy_done", o_busy, 1'b0);
        step();
        check("pulse_seen", pulse_q.size(), 1);
        if (pulse_q.size() > 0) check("pulse_ticks", pulse_q.pop_front(), START_US);
        check("err_code_held", o_err_code, e.code);
        check("data_held", {o_hum_int, o_hum_dec, o_tmp_int, o_tmp_dec}, model_data);
        check("events_drained", exp_q.size(), 0);
    endtask

    function automatic logic [39:0] good_frame(input logic [31:0] d);
        int s;
        s = d[31:24] + d[23:16] + d[15:8] + d[7:0];
        return {d, 8'(s % 256)};
    endfunction

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        dht_in     = 1'b1;
        model_data = 32'd0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_oe", o_dht_oe, 1'b0);
        check("rst_busy", o_busy, 1'b0);
        check("rst_valid_err", {o_valid, o_err}, 2'b00);
        check("rst_err_code", o_err_code, 2'd0);
        check("rst_data", {o_hum_int, o_hum_dec, o_tmp_int, o_tmp_dec}, 32'd0);
        reset = 1'b0;
        step();

        // Widths of exactly 50/51 us for every bit exercise the decode threshold.
        transact(0, 40'h37_00_19_00_50, 1'b1);
        check("hum_int_55", o_hum_int, 8'd55);
        check("tmp_int_25", o_tmp_int, 8'd25);
        transact(0, good_frame($urandom()), 1'b0);
        transact(0, good_frame($urandom()), 1'b0);
        transact(0, 40'h37_00_19_00_51, 1'b0);
        transact(1, 40'd0, 1'b0);
        transact(2, {$urandom(), 8'h00}, 1'b0);

        // Async reset partway through the start pulse.
        start = 1'b1;
        step();
        start = 1'b0;
        hold_us(500);
        reset = 1'b1;
        #1;
        check("midreset_oe", o_dht_oe, 1'b0);
        check("midreset_busy", o_busy, 1'b0);
        check("midreset_data", {o_hum_int, o_hum_dec, o_tmp_int, o_tmp_dec}, 32'd0);
        model_data = 32'd0;
        step();
        step();
        reset = 1'b0;
        step();
        transact(0, good_frame($urandom()), 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/dht11_read_ctrl.md
Name: dht11_read_ctrl

Overview:
- Sequences one DHT11 single-wire transaction and returns humidity/temperature bytes to the LCD display path.
- All protocol timing is measured in microsecond ticks from the shared 1 MHz tick generator; the block never counts raw system clocks.
- Sits between the system-level scheduler (issues `start`) and the top-level DHT11 open-drain pad (`dht_oe` drives low; the pad pull-up releases high).

Parameters:
- START_LOW_US, 18000, host start-pulse low time in µs.
- RESP_TIMEOUT_US, 100, max µs allowed in any sensor-driven wait state before error.
- BIT_THRESH_US, 50, data-bit high time strictly greater than this decodes as 1.
- CNT_W, 15, µs counter width; must hold START_LOW_US.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- tick_1us  in  1  one-clk-wide pulse, once per µs.
- start  in  1  request a read; sampled only in IDLE.
- dht_in  in  1  raw pad input, asynchronous to clk.
- dht_oe  out  1  1 = drive pad low, 0 = release.
- busy  out  1  high in every state except IDLE.
- hum_int, hum_dec, tmp_int, tmp_dec  out  8 each  last good reading.
- valid  out  1  one-clk pulse when a new reading is latched.
- err  out  1  one-clk pulse on timeout or checksum fail.
- err_code  out  2  0 none, 1 no response, 2 bit timeout, 3 checksum; held until the next start.

Behaviour:
- Reset values: dht_oe=0, busy=0, valid=0, err=0, err_code=0, all data bytes=0, state=IDLE, µs counter=0, bit index=0, shift register=0. Reset mid-transaction releases the line on the reset edge.
- dht_in passes through a 2-FF synchronizer. All edge decisions use the synchronized value; the resulting 2-clk latency is tolerated.
- The µs counter clears on every state change and increments only on cycles where tick_1us=1.
- IDLE:
  - On start=1, go to START_LOW next clk with dht_oe=1 and busy=1.
  - start in any other state is ignored.
- START_LOW: when counter reaches START_LOW_US, set dht_oe=0 and go to WAIT_RESP.
- WAIT_RESP: wait for line low. Timeout → ERROR, code 1.
- RESP_LOW: wait for line high. Timeout → ERROR, code 1.
- RESP_HIGH: wait for line low. Timeout → ERROR, code 1.
- BIT_LOW: wait for line high. Timeout → ERROR, code 2.
- BIT_HIGH:
  - On line low, decode the bit: 1 if counter > BIT_THRESH_US, else 0.
  - Shift the bit MSB-first into a 40-bit register and increment the bit index.
  - If index was 39, go to CHECK; otherwise go to BIT_LOW.
  - Timeout → ERROR, code 2.
- Timeout rule: error is taken when the counter reaches RESP_TIMEOUT_US in any wait state.
- CHECK (1 clk):
  - Compare byte sum mod 256 against byte 0 (last received).
  - Pass: latch hum_int=bits[39:32], hum_dec=[31:24], tmp_int=[23:16], tmp_dec=[15:8]; pulse valid; set err_code=0; go to IDLE.
  - Fail: go to ERROR, code 3.
- ERROR (1 clk): pulse err, hold err_code, data outputs unchanged, dht_oe=0, go to IDLE.
- Data outputs change only on valid.
- Without tick_1us the FSM stalls indefinitely in timed states; this is legal.

Optional Feature:
- Macro: DHT11_AUTO_RETRY_EN.
- When defined:
  - An error with code 1 or 2 does not return to IDLE. The block holds in a RETRY_WAIT state for START_LOW_US µs, then re-enters START_LOW.
  - At most 1 retry per start. err pulses only when the retry also fails; busy stays high throughout.
  - A checksum error (code 3) is never retried.
- When undefined: no RETRY_WAIT state and no retry counter; every error goes directly to IDLE.

Decomposition:
- Package dht11_pkg holds:
  - the state enum (IDLE, START_LOW, WAIT_RESP, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH, CHECK, ERROR, RETRY_WAIT);
  - the err_code constants ERR_NONE, ERR_NORESP, ERR_BIT, ERR_CSUM;
  - the frame-length constant DHT_BITS=40.
- One sub-module, dht11_in_sync: the 2-FF synchronizer with reset value 1 (idle line high).

Test Plan:
- Good frame: start, sensor model answers (80/80 µs response) and sends bytes 0x37,0x00,0x19,0x00,0x50 → valid pulses once, hum_int=55, tmp_int=25, err stays 0, busy falls the same clk.
- Start pulse timing: start → dht_oe=1 for exactly 18000 ticks, then 0; start re-asserted at tick 100 has no effect.
- No sensor (line held high) → err pulse after 100 µs in WAIT_RESP, err_code=1, dht_oe=0, previous data unchanged. With DHT11_AUTO_RETRY_EN, a second start pulse appears first and err arrives after the second timeout.
- Bad checksum (last byte 0x51) → err with code 3, valid never asserts, data outputs unchanged from the prior good read.
- Bit threshold: high widths of 50 µs and 51 µs → decoded as 0 and 1 respectively; sensor stops mid-frame at bit 20 → err code 2 after 100 µs.
- Async reset at tick 5000 of START_LOW → dht_oe=0 and busy=0 immediately; the next start performs a full 18000 µs pulse.
